// File: rtl/ndt_link_rx.sv
// ndt_link_rx
// Reassembles a data_size+tag_size NDT word from a narrow serial link.
// Beats arrive MSB-first (data first, tag last) with a start-of-frame
// marker; each completed word is held on a valid/ready output until the
// pipeline consumes it. Framing violations are flagged and counted.
//
// Ports:
//   clk           - single clock, all logic on posedge
//   reset         - asynchronous, active-low
//   link_valid    - beat present on link_data
//   link_sof      - beat is the first beat of a frame
//   link_data     - beat payload, lane_width bits
//   link_ready    - receiver accepts a beat this cycle
//   ndt_valid     - ndt_out holds a complete frame
//   ndt_ready     - downstream consumes ndt_out this cycle
//   ndt_out       - assembled word, data in MSBs, tag in low tag_size bits
//   framing_error - one-cycle pulse per framing violation
//   frame_count   - completed frames, wraps
//   error_count   - framing errors, saturates at 0xFF
module ndt_link_rx #(
    parameter int data_size  = 32,
    parameter int tag_size   = 8,
    parameter int lane_width = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            link_valid,
    input  logic                            link_sof,
    input  logic [lane_width-1:0]           link_data,
    output logic                            link_ready,
    output logic                            ndt_valid,
    input  logic                            ndt_ready,
    output logic [data_size+tag_size-1:0]   ndt_out,
    output logic                            framing_error,
    output logic [15:0]                     frame_count,
    output logic [7:0]                      error_count
);

    localparam int W  = data_size + tag_size;
    localparam int N  = W / lane_width;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    shreg_q, shreg_d, merged;
    logic [CW-1:0]   pos;
    logic            accept, complete, err, store, start;

    // While a word is waiting, a new beat can only enter on the same edge
    // that hands the word downstream, so ready passes straight through.
    assign link_ready = (state_q == HOLD) ? ndt_ready : 1'b1;
    assign accept     = link_valid & link_ready;

    // Next-state logic. Every path that begins a new frame raises 'start';
    // the shared beat-0 handling below then decides between collecting more
    // beats or completing at once (single-beat frames).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        pos      = cnt_q;
        complete = 1'b0;
        err      = 1'b0;
        store    = 1'b0;
        start    = 1'b0;
        merged   = shreg_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (link_sof) start = 1'b1;
                    else          err   = 1'b1;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (link_sof) begin
                        err   = 1'b1;
                        start = 1'b1;
                    end else begin
                        store = 1'b1;
                        if (cnt_q == LAST) complete = 1'b1;
                        else               cnt_d    = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (ndt_ready) begin
                    state_d = IDLE;
                    if (link_valid) begin
                        if (link_sof) start = 1'b1;
                        else          err   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            pos   = '0;
            store = 1'b1;
            if (N == 1) begin
                complete = 1'b1;
            end else begin
                cnt_d   = CW'(1);
                state_d = COLLECT;
            end
        end

        // Beat 0 starts from a clean register so a discarded partial frame
        // can never leak bytes into the next word.
        if (start) merged = '0;
        for (int k = 0; k < N; k++) begin
            if (store && (CW'(k) == pos))
                merged[W-1-k*lane_width -: lane_width] = link_data;
        end

        if (store) shreg_d = complete ? '0 : merged;

        if (complete) begin
            state_d = HOLD;
            cnt_d   = '0;
        end
    end

    // State, assembly register, output word and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            ndt_out       <= '0;
            ndt_valid     <= 1'b0;
            framing_error <= 1'b0;
            frame_count   <= '0;
            error_count   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            framing_error <= err;
            if (complete) begin
                ndt_out     <= merged;
                ndt_valid   <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (ndt_ready) begin
                ndt_valid <= 1'b0;
            end
            if (err && (error_count != 8'hFF))
                error_count <= error_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_ndt_link_rx.sv
// tb_ndt_link_rx
// Scoreboard bench for ndt_link_rx. A frame-level reference model predicts
// completed words (pushed into a queue), handshake readiness, error pulses
// and counters; a monitor pops and compares words on each output transfer.
// A second instance with lane_width=40 covers single-beat frames.
module tb_ndt_link_rx;

    localparam int W = 40;
    localparam int N = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        link_valid = 1'b0, link_sof = 1'b0, ndt_ready = 1'b0;
    logic [7:0]  link_data = '0;
    logic        link_ready, ndt_valid, framing_error;
    logic [W-1:0] ndt_out;
    logic [15:0] frame_count;
    logic [7:0]  error_count;

    logic        v1 = 1'b0, s1 = 1'b0, r1 = 1'b0;
    logic [W-1:0] d1 = '0;
    logic        link_ready_1, ndt_valid_1, framing_error_1;
    logic [W-1:0] ndt_out_1;
    logic [15:0] frame_count_1;
    logic [7:0]  error_count_1;

    int checks = 0;
    int fails  = 0;

    logic [W-1:0] exp_q[$];
    bit           m_pending;
    bit           m_err;
    logic [7:0]   m_part[$];
    logic [15:0]  m_frames;
    logic [7:0]   m_errors;

    always #5 clk = ~clk;

    ndt_link_rx u_dut (
        .clk(clk), .reset(reset), .link_valid(link_valid), .link_sof(link_sof),
        .link_data(link_data), .link_ready(link_ready), .ndt_valid(ndt_valid),
        .ndt_ready(ndt_ready), .ndt_out(ndt_out), .framing_error(framing_error),
        .frame_count(frame_count), .error_count(error_count)
    );

    ndt_link_rx #(.data_size(32), .tag_size(8), .lane_width(40)) u_dut1 (
        .clk(clk), .reset(reset), .link_valid(v1), .link_sof(s1),
        .link_data(d1), .link_ready(link_ready_1), .ndt_valid(ndt_valid_1),
        .ndt_ready(r1), .ndt_out(ndt_out_1), .framing_error(framing_error_1),
        .frame_count(frame_count_1), .error_count(error_count_1)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pending = 0;
        m_err     = 0;
        m_part.delete();
        m_frames  = '0;
        m_errors  = '0;
        exp_q.delete();
    endtask

    // Frame-level model: a frame is the list of bytes since the last sof;
    // it completes when it holds N bytes.
    task automatic modelStep(input bit v, input bit sof, input logic [7:0] d, input bit rdy);
        bit ready;
        logic [W-1:0] word;
        ready = m_pending ? rdy : 1'b1;
        m_err = 0;
        if (m_pending && rdy) m_pending = 0;
        if (v && ready) begin
            if (sof) begin
                if (m_part.size() > 0) m_err = 1;
                m_part.delete();
                m_part.push_back(d);
            end else if (m_part.size() == 0) begin
                m_err = 1;
            end else begin
                m_part.push_back(d);
            end
            if (m_part.size() == N) begin
                word = '0;
                foreach (m_part[i]) word = {word[W-9:0], m_part[i]};
                exp_q.push_back(word);
                m_frames  = m_frames + 16'd1;
                m_pending = 1;
                m_part.delete();
            end
        end
        if (m_err && (m_errors != 8'hFF)) m_errors = m_errors + 8'd1;
    endtask

    // Entered just after a posedge; returns just after the next posedge.
    task automatic applyStimulus(input bit v, input bit sof, input logic [7:0] d, input bit rdy);
        link_valid = v;
        link_sof   = sof;
        link_data  = d;
        ndt_ready  = rdy;
        @(negedge clk);
        checkOutput("link_ready", 64'(link_ready), m_pending ? 64'(rdy) : 64'd1);
        @(posedge clk);
        modelStep(v, sof, d, rdy);
        #1;
        checkOutput("ndt_valid", 64'(ndt_valid), 64'(m_pending));
        checkOutput("framing_error", 64'(framing_error), 64'(m_err));
        checkOutput("frame_count", 64'(frame_count), 64'(m_frames));
        checkOutput("error_count", 64'(error_count), 64'(m_errors));
    endtask

    task automatic sendFrame(input logic [W-1:0] word, input bit rdy);
        for (int i = 0; i < N; i++)
            applyStimulus(1'b1, i == 0, word[W-1-i*8 -: 8], rdy);
    endtask

    // Monitor: a transfer happens at the next posedge when valid & ready.
    always @(negedge clk) begin
        if (reset && ndt_valid && ndt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL scoreboard_word: got %0h, expected none queued", ndt_out);
            end else begin
                checkOutput("scoreboard_word", 64'(ndt_out), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [W-1:0] rnd, last;
        modelReset();
        #12;
        checkOutput("reset_ndt_out", 64'(ndt_out), 64'd0);
        checkOutput("reset_ndt_valid", 64'(ndt_valid), 64'd0);
        checkOutput("reset_frame_count", 64'(frame_count), 64'd0);
        checkOutput("reset_error_count", 64'(error_count), 64'd0);
        checkOutput("reset_link_ready", 64'(link_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] back-to-back frame");
        sendFrame(40'hDEADBEEF5A, 1'b1);
        checkOutput("ndt_out_first", 64'(ndt_out), 64'hDEADBEEF5A);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] backpressure with sof waiting");
        sendFrame(40'hDEADBEEF5A, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'h11, 1'b0);
        checkOutput("ndt_out_held", 64'(ndt_out), 64'hDEADBEEF5A);
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h22, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h44, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h55, 1'b1);
        checkOutput("ndt_out_second", 64'(ndt_out), 64'h1122334455);

        $display("[TB] sof restart");
        applyStimulus(1'b1, 1'b1, 8'h01, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h02, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h03, 1'b1);
        sendFrame(40'h0A0B0C0D0E, 1'b1);
        checkOutput("ndt_out_restart", 64'(ndt_out), 64'h0A0B0C0D0E);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        $display("[TB] stray beats and saturation");
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b0, 8'(i), 1'b1);
        checkOutput("error_count_sat", 64'(error_count), 64'hFF);

        $display("[TB] async reset mid-frame");
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h88, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h99, 1'b1);
        #2;
        reset = 1'b0;
        link_valid = 1'b0;
        link_sof = 1'b0;
        #1;
        checkOutput("areset_ndt_out", 64'(ndt_out), 64'd0);
        checkOutput("areset_frame_count", 64'(frame_count), 64'd0);
        checkOutput("areset_error_count", 64'(error_count), 64'd0);
        checkOutput("areset_ndt_valid", 64'(ndt_valid), 64'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sendFrame(40'hAABBCCDDEE, 1'b1);
        checkOutput("ndt_out_after_reset", 64'(ndt_out), 64'hAABBCCDDEE);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 5) == 0,
                          8'($urandom), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] single-beat frames");
        last = '0;
        for (int i = 0; i < 8; i++) begin
            rnd = {$urandom, 8'($urandom)};
            v1 = 1'b1; s1 = 1'b1; d1 = rnd; r1 = 1'b1;
            @(negedge clk);
            checkOutput("n1_link_ready", 64'(link_ready_1), 64'd1);
            @(posedge clk);
            #1;
            checkOutput("n1_ndt_valid", 64'(ndt_valid_1), 64'd1);
            checkOutput("n1_ndt_out", 64'(ndt_out_1), 64'(rnd));
            checkOutput("n1_frame_count", 64'(frame_count_1), 64'(i + 1));
            last = rnd;
        end
        d1 = ~last; r1 = 1'b0;
        @(negedge clk);
        checkOutput("n1_link_ready_hold", 64'(link_ready_1), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("n1_ndt_out_held", 64'(ndt_out_1), 64'(last));
        s1 = 1'b0; r1 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("n1_valid_after_stray", 64'(ndt_valid_1), 64'd0);
        checkOutput("n1_framing_error", 64'(framing_error_1), 64'd1);
        checkOutput("n1_error_count", 64'(error_count_1), 64'd1);
        checkOutput("n1_ndt_out_kept", 64'(ndt_out_1), 64'(last));
        v1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("n1_error_pulse_end", 64'(framing_error_1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
